// File: rtl/cpu_controller_p_if.sv
// Bundle of decode fields, ALU flags, memory handshake and datapath strobes
// exchanged between the CPU controller (master) and the datapath (slave).
interface cpu_controller_p_if #(
   parameter int REG_AW = 3
);
   logic [6:0]        opc;
   logic [REG_AW-1:0] opd1;
   logic [REG_AW-1:0] opd2;
   logic [REG_AW-1:0] opd3;
   logic              C;
   logic              V;
   logic              S;
   logic              Z_det;
   logic              mem_ready;
   logic              ldPC;
   logic              ldIR;
   logic              ldMAR;
   logic              rd_mem;
   logic              wr_mem;
   logic              rd_reg;
   logic              wr_reg;
   logic              ldXreg;
   logic              ldYreg;
   logic              ldALU;
   logic              pc_sel;
   logic              wb_sel;
   logic [REG_AW-1:0] rd_regA;
   logic [REG_AW-1:0] wr_regA;
   logic [2:0]        fsel;
   logic [3:0]        state;
   logic [3:0]        flags;
   logic              illegal;
   logic              bus_err;
   logic              halted;

   modport master (
      input  opc, opd1, opd2, opd3, C, V, S, Z_det, mem_ready,
      output ldPC, ldIR, ldMAR, rd_mem, wr_mem, rd_reg, wr_reg, ldXreg, ldYreg, ldALU,
      output pc_sel, wb_sel, rd_regA, wr_regA, fsel, state, flags, illegal, bus_err, halted
   );

   modport slave (
      output opc, opd1, opd2, opd3, C, V, S, Z_det, mem_ready,
      input  ldPC, ldIR, ldMAR, rd_mem, wr_mem, rd_reg, wr_reg, ldXreg, ldYreg, ldALU,
      input  pc_sel, wb_sel, rd_regA, wr_regA, fsel, state, flags, illegal, bus_err, halted
   );
endinterface

// File: rtl/cpu_controller_p.sv
// Multi-cycle CPU control FSM: fetch/decode/execute sequencing with a timed
// memory handshake, latched ALU flags, conditional branches and sticky halt/bus error.
module cpu_controller_p #(
   parameter int REG_AW   = 3,
   parameter int WAIT_MAX = 15
) (
   input logic                clk,
   input logic                reset,
   cpu_controller_p_if.master bus
);
   typedef enum logic [3:0] {
      S_FETCH0 = 4'd0, S_FETCH1 = 4'd1, S_DECODE = 4'd2, S_ALU0 = 4'd3,
      S_ALU1   = 4'd4, S_ALU2   = 4'd5, S_WB     = 4'd6, S_MEM0 = 4'd7,
      S_LD1    = 4'd8, S_ST1    = 4'd9, S_BR0    = 4'd10, S_HALT = 4'd11
   } state_e;

   localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

   state_e     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic [3:0] flags_q, flags_d;
   logic       bus_err_q, bus_err_d;
   logic       halted_q, halted_d;
   logic       is_alu_s, is_ld_s, is_st_s, is_br_s, is_halt_s, is_ill_s;
   logic       wait_hit_s;

   // Branch condition against latched flags {C,V,S,Z}.
   function automatic logic branch_taken(input logic [2:0] cond, input logic [3:0] f);
      case (cond)
         3'd0:    branch_taken = 1'b1;
         3'd1:    branch_taken = f[0];
         3'd2:    branch_taken = f[3];
         3'd3:    branch_taken = f[2];
         3'd4:    branch_taken = f[1];
         3'd5:    branch_taken = ~f[0];
         3'd6:    branch_taken = ~f[3];
         default: branch_taken = 1'b0;
      endcase
   endfunction

   // Opcode class decode from the major opcode field.
   always_comb begin
      is_alu_s  = 1'b0;
      is_ld_s   = 1'b0;
      is_st_s   = 1'b0;
      is_br_s   = 1'b0;
      is_halt_s = 1'b0;
      is_ill_s  = 1'b0;
      case (bus.opc[6:3])
         4'b0000: is_alu_s  = 1'b1;
         4'b0110: is_ld_s   = 1'b1;
         4'b0111: is_st_s   = 1'b1;
         4'b1000: is_br_s   = 1'b1;
         4'b1111: is_halt_s = 1'b1;
         default: is_ill_s  = 1'b1;
      endcase
   end

   assign wait_hit_s = ((wait_q + 8'd1) == WAIT_LIM);

   // State, wait counter, flags and sticky status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH0;
         wait_q    <= 8'd0;
         flags_q   <= 4'd0;
         bus_err_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         flags_q   <= flags_d;
         bus_err_q <= bus_err_d;
         halted_q  <= halted_d;
      end
   end

   // Next-state logic; memory states share the ready/timeout rule.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      flags_d   = flags_q;
      bus_err_d = bus_err_q;
      halted_d  = halted_q;
      case (state_q)
         S_FETCH0: begin
            state_d = S_FETCH1;
            wait_d  = 8'd0;
         end
         S_FETCH1, S_LD1, S_ST1: begin
            if (bus.mem_ready) begin
               state_d = (state_q == S_FETCH1) ? S_DECODE : S_FETCH0;
            end else if (wait_hit_s) begin
               state_d   = S_HALT;
               bus_err_d = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            if (is_alu_s) begin
               state_d = S_ALU0;
            end else if (is_ld_s || is_st_s) begin
               state_d = S_MEM0;
            end else if (is_br_s) begin
               state_d = S_BR0;
            end else if (is_halt_s) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH0;
            end
         end
         S_ALU0: state_d = S_ALU1;
         S_ALU1: state_d = S_ALU2;
         S_ALU2: begin
            state_d = S_WB;
            flags_d = {bus.C, bus.V, bus.S, bus.Z_det};
         end
         S_WB:   state_d = S_FETCH0;
         S_MEM0: begin
            state_d = is_ld_s ? S_LD1 : S_ST1;
            wait_d  = 8'd0;
         end
         S_BR0:  state_d = S_FETCH0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH0;
      endcase
      if (state_d == S_HALT) begin
         halted_d = 1'b1;
      end else begin
         halted_d = halted_q;
      end
   end

   // Datapath strobes decoded from state, operands and mem_ready.
   always_comb begin
      bus.ldPC    = 1'b0;
      bus.ldIR    = 1'b0;
      bus.ldMAR   = 1'b0;
      bus.rd_mem  = 1'b0;
      bus.wr_mem  = 1'b0;
      bus.rd_reg  = 1'b0;
      bus.wr_reg  = 1'b0;
      bus.ldXreg  = 1'b0;
      bus.ldYreg  = 1'b0;
      bus.ldALU   = 1'b0;
      bus.pc_sel  = 1'b0;
      bus.wb_sel  = 1'b0;
      bus.rd_regA = '0;
      bus.wr_regA = '0;
      bus.fsel    = 3'd0;
      bus.illegal = 1'b0;
      if (reset) begin
         // state_q already reads FETCH0 here; keep its ldMAR from leaking out
         bus.ldMAR = 1'b0;
      end else begin
         case (state_q)
            S_FETCH0: bus.ldMAR = 1'b1;
            S_FETCH1: begin
               bus.rd_mem = 1'b1;
               bus.ldIR   = bus.mem_ready;
            end
            S_DECODE: begin
               bus.ldPC    = 1'b1;
               bus.illegal = is_ill_s;
            end
            S_ALU0: begin
               bus.rd_reg  = 1'b1;
               bus.rd_regA = bus.opd2;
               bus.ldXreg  = 1'b1;
            end
            S_ALU1: begin
               bus.rd_reg  = 1'b1;
               bus.rd_regA = bus.opd3;
               bus.ldYreg  = 1'b1;
            end
            S_ALU2: begin
               bus.ldALU = 1'b1;
               bus.fsel  = bus.opc[2:0];
            end
            S_WB: begin
               bus.wr_reg  = 1'b1;
               bus.wr_regA = bus.opd1;
            end
            S_MEM0: begin
               bus.rd_reg  = 1'b1;
               bus.rd_regA = bus.opd2;
               bus.ldMAR   = 1'b1;
            end
            S_LD1: begin
               bus.rd_mem = 1'b1;
               if (bus.mem_ready) begin
                  bus.wr_reg  = 1'b1;
                  bus.wr_regA = bus.opd1;
                  bus.wb_sel  = 1'b1;
               end else begin
                  bus.wr_reg = 1'b0;
               end
            end
            S_ST1: begin
               bus.rd_reg  = 1'b1;
               bus.rd_regA = bus.opd1;
               bus.wr_mem  = 1'b1;
            end
            S_BR0: begin
               bus.rd_reg  = 1'b1;
               bus.rd_regA = bus.opd1;
               bus.ldPC    = branch_taken(bus.opc[2:0], flags_q);
               bus.pc_sel  = branch_taken(bus.opc[2:0], flags_q);
            end
            default: bus.ldPC = 1'b0;
         endcase
      end
   end

   assign bus.state   = state_q;
   assign bus.flags   = flags_q;
   assign bus.bus_err = bus_err_q;
   assign bus.halted  = halted_q;
endmodule

// File: tb/tb_cpu_controller_p.sv
// Scoreboard bench: the driver expands each instruction into per-cycle expected
// outputs from the instruction-level rules; a negedge monitor pops and compares.
module tb_cpu_controller_p;
   localparam int WMAX = 4;

   typedef struct packed {
      logic       ldPC, ldIR, ldMAR, rd_mem, wr_mem, rd_reg, wr_reg, ldXreg, ldYreg, ldALU, pc_sel, wb_sel;
      logic [2:0] rd_regA, wr_regA, fsel;
      logic [3:0] state, flags;
      logic       illegal, bus_err, halted;
   } obs_t;

   logic clk;
   logic reset;
   cpu_controller_p_if #(.REG_AW(3)) bus ();
   cpu_controller_p #(.REG_AW(3), .WAIT_MAX(WMAX)) dut (.clk(clk), .reset(reset), .bus(bus));

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic fC, fV, fS, fZ, berr_m, halt_m;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t a;
      a.ldPC = bus.ldPC;     a.ldIR = bus.ldIR;       a.ldMAR = bus.ldMAR;
      a.rd_mem = bus.rd_mem; a.wr_mem = bus.wr_mem;   a.rd_reg = bus.rd_reg;
      a.wr_reg = bus.wr_reg; a.ldXreg = bus.ldXreg;   a.ldYreg = bus.ldYreg;
      a.ldALU = bus.ldALU;   a.pc_sel = bus.pc_sel;   a.wb_sel = bus.wb_sel;
      a.rd_regA = bus.rd_regA; a.wr_regA = bus.wr_regA; a.fsel = bus.fsel;
      a.state = bus.state;   a.flags = bus.flags;     a.illegal = bus.illegal;
      a.bus_err = bus.bus_err; a.halted = bus.halted;
      return a;
   endfunction

   function automatic obs_t base(input logic [3:0] st);
      obs_t e;
      e = '0;
      e.state   = st;
      e.flags   = {fC, fV, fS, fZ};
      e.bus_err = berr_m;
      e.halted  = halt_m;
      return e;
   endfunction

   function automatic logic cond_ok(input logic [2:0] c);
      case (c)
         3'd0:    cond_ok = 1'b1;
         3'd1:    cond_ok = fZ;
         3'd2:    cond_ok = fC;
         3'd3:    cond_ok = fV;
         3'd4:    cond_ok = fS;
         3'd5:    cond_ok = !fZ;
         3'd6:    cond_ok = !fC;
         default: cond_ok = 1'b0;
      endcase
   endfunction

   // monitor
   always @(negedge clk) begin
      obs_t e;
      obs_t a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = sample();
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL outputs state=%0d t=%0t: got %h, expected %h", e.state, $time, a, e);
         end
      end
   end

   task automatic chk(input logic ok_c, input string what);
      n_checks++;
      if (ok_c !== 1'b1) begin
         n_fail++;
         $display("FAIL %s t=%0t: state=%0d bus_err=%b halted=%b", what, $time,
                  bus.state, bus.bus_err, bus.halted);
      end
   endtask

   task automatic cyc(input obs_t e, input logic mr);
      bus.mem_ready = mr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic mem_phase(input obs_t wt, input obs_t dn, input int w, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < w; i++) begin
         cyc(wt, 1'b0);
         if (i + 1 == WMAX) begin
            berr_m = 1'b1;
            halt_m = 1'b1;
            return;
         end
      end
      cyc(dn, 1'b1);
      ok = 1'b1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      fC = 1'b0; fV = 1'b0; fS = 1'b0; fZ = 1'b0;
      berr_m = 1'b0;
      halt_m = 1'b0;
      #1;
      chk((bus.state === 4'd0) && (bus.flags === 4'd0) && (bus.bus_err === 1'b0) &&
          (bus.halted === 1'b0) && (bus.ldMAR === 1'b0) && (bus.rd_mem === 1'b0) &&
          (bus.wr_mem === 1'b0) && (bus.illegal === 1'b0), "reset state");
      repeat (5) cyc('0, 1'($urandom));
      reset = 1'b0;
   endtask

   task automatic halt_hold(input int n);
      repeat (n) cyc(base(4'd11), 1'($urandom));
   endtask

   task automatic exec(input logic [6:0] op, input logic [2:0] d1, input logic [2:0] d2,
                       input logic [2:0] d3, input logic [3:0] cvsz, input int wf, input int wm);
      obs_t e;
      obs_t dn;
      bit   ok;
      bus.opc = op; bus.opd1 = d1; bus.opd2 = d2; bus.opd3 = d3;
      {bus.C, bus.V, bus.S, bus.Z_det} = cvsz;
      e = base(4'd0); e.ldMAR = 1'b1;
      cyc(e, 1'($urandom));
      e = base(4'd1); e.rd_mem = 1'b1;
      dn = e; dn.ldIR = 1'b1;
      mem_phase(e, dn, wf, ok);
      if (!ok) return;
      e = base(4'd2); e.ldPC = 1'b1;
      case (op[6:3])
         4'b0000, 4'b0110, 4'b0111, 4'b1000, 4'b1111: e.illegal = 1'b0;
         default: e.illegal = 1'b1;
      endcase
      cyc(e, 1'($urandom));
      case (op[6:3])
         4'b0000: begin
            e = base(4'd3); e.rd_reg = 1'b1; e.rd_regA = d2; e.ldXreg = 1'b1;
            cyc(e, 1'($urandom));
            e = base(4'd4); e.rd_reg = 1'b1; e.rd_regA = d3; e.ldYreg = 1'b1;
            cyc(e, 1'($urandom));
            e = base(4'd5); e.ldALU = 1'b1; e.fsel = op[2:0];
            cyc(e, 1'($urandom));
            {fC, fV, fS, fZ} = cvsz;
            e = base(4'd6); e.wr_reg = 1'b1; e.wr_regA = d1;
            cyc(e, 1'($urandom));
         end
         4'b0110, 4'b0111: begin
            e = base(4'd7); e.rd_reg = 1'b1; e.rd_regA = d2; e.ldMAR = 1'b1;
            cyc(e, 1'($urandom));
            if (op[3] == 1'b0) begin
               e = base(4'd8); e.rd_mem = 1'b1;
               dn = e; dn.wr_reg = 1'b1; dn.wr_regA = d1; dn.wb_sel = 1'b1;
            end else begin
               e = base(4'd9); e.rd_reg = 1'b1; e.rd_regA = d1; e.wr_mem = 1'b1;
               dn = e;
            end
            mem_phase(e, dn, wm, ok);
         end
         4'b1000: begin
            e = base(4'd10); e.rd_reg = 1'b1; e.rd_regA = d1;
            e.ldPC = cond_ok(op[2:0]); e.pc_sel = cond_ok(op[2:0]);
            cyc(e, 1'($urandom));
         end
         4'b1111: halt_m = 1'b1;
         default: ok = 1'b1;
      endcase
   endtask

   initial begin
      int ill[11] = '{1, 2, 3, 4, 5, 9, 10, 11, 12, 13, 14};
      logic [3:0] top;
      reset = 1'b1;
      bus.mem_ready = 1'b0;
      bus.opc = 7'd0; bus.opd1 = 3'd0; bus.opd2 = 3'd0; bus.opd3 = 3'd0;
      {bus.C, bus.V, bus.S, bus.Z_det} = 4'd0;
      @(posedge clk);
      #1;
      do_reset();
      exec(7'b0000_010, 3'd3, 3'd1, 3'd2, 4'b1000, 0, 0);
      exec(7'b0110_000, 3'd5, 3'd4, 3'd0, 4'b0000, 0, 3);
      exec(7'b0111_000, 3'd6, 3'd2, 3'd0, 4'b0000, 2, 1);
      exec(7'b0000_111, 3'd1, 3'd1, 3'd1, 4'b0001, 0, 0);
      exec(7'b1000_001, 3'd7, 3'd0, 3'd0, 4'b0000, 0, 0);
      exec(7'b0000_000, 3'd1, 3'd1, 3'd1, 4'b0000, 0, 0);
      exec(7'b1000_001, 3'd7, 3'd0, 3'd0, 4'b0000, 0, 0);
      exec(7'b1010_000, 3'd2, 3'd3, 3'd4, 4'b0000, 0, 0);
      exec(7'b0000_101, 3'd2, 3'd3, 3'd4, 4'b1111, 3, 0);
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 5))
            0:       top = 4'b0000;
            1:       top = 4'b0110;
            2:       top = 4'b0111;
            3, 4:    top = 4'b1000;
            default: top = 4'(ill[$urandom_range(0, 10)]);
         endcase
         exec({top, 3'($urandom)}, 3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3));
      end
      exec(7'b1111_000, 3'd0, 3'd0, 3'd0, 4'b0000, 1, 0);
      halt_hold(20);
      do_reset();
      exec(7'b0000_011, 3'd1, 3'd2, 3'd3, 4'b0100, 10, 0);
      chk((bus.bus_err === 1'b1) && (bus.halted === 1'b1) && (bus.state === 4'd11),
          "expired wait");
      halt_hold(5);
      do_reset();
      exec(7'b0110_000, 3'd1, 3'd2, 3'd3, 4'b0000, 0, 9);
      halt_hold(3);
      do_reset();
      exec(7'b0111_000, 3'd1, 3'd2, 3'd3, 4'b0000, 0, 4);
      halt_hold(3);
      do_reset();
      begin
         obs_t e;
         e = base(4'd0); e.ldMAR = 1'b1;
         cyc(e, 1'b0);
         e = base(4'd1); e.rd_mem = 1'b1;
         cyc(e, 1'b0);
         cyc(e, 1'b0);
      end
      do_reset();
      exec(7'b0000_001, 3'd4, 3'd5, 3'd6, 4'b0010, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cpu_controller_p.md
# cpu_controller_p

Parametrised multi-cycle CPU control unit: owns its own state register, decodes a 7-bit opcode plus three register-address operands, and sequences PC, IR, MAR, register-file, ALU and memory strobes. Successor to the fixed-width CPU_controller. It adds a configurable register-address width, a ready/wait memory handshake with timeout, latched ALU flags with conditional branches, and explicit HALT/illegal-opcode handling. Sits between instruction decode and the datapath in the CPU top.

## Interface
- REG_AW, 3, register-address width (register file holds 2^REG_AW entries)
- WAIT_MAX, 15, max cycles a memory access may wait for mem_ready before bus error (1..255)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clock is clk
- opc  in  7  opcode field of IR
- opd1, opd2, opd3  in  REG_AW each  operand register addresses from IR
- C, V, S, Z_det  in  1 each  ALU carry/overflow/sign/zero, valid while ldALU=1
- mem_ready  in  1  memory completes current rd_mem/wr_mem this cycle
- ldPC, ldIR, ldMAR, rd_mem, wr_mem, rd_reg, wr_reg, ldXreg, ldYreg, ldALU  out  1 each  datapath strobes
- pc_sel  out  1  0: PC<=PC+1, 1: PC<=reg data
- wb_sel  out  1  0: write-back from ALU, 1: from memory data
- rd_regA, wr_regA  out  REG_AW  register-file addresses
- fsel  out  3  ALU function
- state  out  4  current state encoding
- flags  out  4  latched {C,V,S,Z}
- illegal  out  1  one-cycle pulse on undefined opcode
- bus_err, halted  out  1 each  sticky until reset

## Operation
- Decode by opc[6:3]: 0000 ALU (fsel=opc[2:0], R[opd1]<=R[opd2] op R[opd3]); 0110 LOAD (R[opd1]<=M[R[opd2]]); 0111 STORE (M[R[opd2]]<=R[opd1]); 1000 BRANCH (PC<=R[opd1] if cond opc[2:0]); 1111 HALT; all others illegal.
- Branch cond: 000 always, 001 Z, 010 C, 011 V, 100 S, 101 !Z, 110 !C, 111 never; evaluated on latched flags.
- States (encoding 0..11): FETCH0, FETCH1, DECODE, ALU0, ALU1, ALU2, WB, MEM0, LD1, ST1, BR0, HALT.
- FETCH0: ldMAR=1 -> FETCH1.
- FETCH1: rd_mem=1; on mem_ready ldIR=1 -> DECODE; else stay.
- DECODE: ldPC=1, pc_sel=0; ALU->ALU0, LOAD/STORE->MEM0, BRANCH->BR0, HALT->HALT, illegal: illegal=1 -> FETCH0.
- ALU0: rd_reg=1, rd_regA=opd2, ldXreg=1 -> ALU1. ALU1: same with opd3, ldYreg -> ALU2.
- ALU2: ldALU=1, fsel=opc[2:0]; flags<={C,V,S,Z_det} at clock edge -> WB.
- WB: wr_reg=1, wr_regA=opd1, wb_sel=0 -> FETCH0.
- MEM0: rd_reg=1, rd_regA=opd2, ldMAR=1 -> LD1 (LOAD) or ST1 (STORE).
- LD1: rd_mem=1; on mem_ready wr_reg=1, wr_regA=opd1, wb_sel=1 -> FETCH0.
- ST1: rd_reg=1, rd_regA=opd1, wr_mem=1 held; on mem_ready -> FETCH0.
- BR0: rd_reg=1, rd_regA=opd1; cond true: ldPC=1, pc_sel=1. Always -> FETCH0.
- HALT: all strobes 0, halted=1; exit only via reset.
- Wait counter: cleared on entering FETCH1/LD1/ST1, increments each cycle mem_ready=0; reaching WAIT_MAX with mem_ready=0 sets bus_err -> HALT. mem_ready on the WAIT_MAX-th cycle wins over timeout.
- Unused output fields (fsel, addresses, selects) drive 0 outside their states.

## Timing
- state, flags, wait counter, bus_err, halted registered; strobes combinational from state, opc/opd and mem_ready.
- Reset (any time, incl. mid-access): state=FETCH0, flags=0, counter=0, bus_err=0, halted=0; all outputs forced 0 while reset high. First ldMAR the cycle after reset release.
- Latency with zero-wait memory (mem_ready=1): ALU 7 cycles, LOAD 5, STORE 5, BRANCH 4, illegal 3.
- Each memory wait cycle adds one cycle; rd_mem/wr_mem held stable until mem_ready.
- opc/opd must remain stable from DECODE until return to FETCH0 (IR held).

## Test plan
- Reset held 5 cycles then released, mem_ready=1 -> all outputs 0 during reset; state sequence 0,1,2 and ldIR high in state 1.
- opc=0000_010, opd1=3,opd2=1,opd3=2, ALU C=1,Z_det=0 -> rd_regA 1 then 2, fsel=2 with ldALU, wr_regA=3 in WB, flags=4'b1000, 7 cycles total.
- LOAD opd1=5,opd2=4, mem_ready low 3 cycles in LD1 -> rd_mem held 4 cycles, single wr_reg pulse, wr_regA=5, wb_sel=1.
- BRANCH opc=1000_001 with flags Z=1 -> ldPC=1, pc_sel=1 in BR0; repeat with Z=0 -> ldPC=0.
- opc=1010_000 -> illegal one-cycle pulse in DECODE, back to FETCH0; opc=1111_000 -> halted=1, state=11 persists 20 cycles.
- WAIT_MAX=4, mem_ready stuck 0 in FETCH1 -> bus_err=1 and HALT after 4 wait cycles; reset asserted mid-wait -> immediate return to FETCH0, bus_err cleared.
